// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding and
// the quotient pattern reported on divide-by-zero.
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 5;

    localparam logic [WIDTH-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_16_if.sv
// Request/response bundle between ALU control (master) and the divider (slave).
interface seq_divider_16_if #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             Ready;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             DivZero;
    logic             Overflow;

    modport master (
        output Start, Signed, x, y,
        input  Ready, Busy, Done, q, r, DivZero, Overflow
    );

    modport slave (
        input  Start, Signed, x, y,
        output Ready, Busy, Done, q, r, DivZero, Overflow
    );
endinterface

// File: rtl/seq_divider_16_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_out_c,
    output logic             q_bit_c
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Partial remainder is always below the divisor, so WIDTH+1 bits suffice
    always_comb begin
        shifted = {p_in, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit_c = ~trial[WIDTH];
        p_out_c = q_bit_c ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider_16.sv
// Iterative restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add two's-complement (truncating) division.
module seq_divider_16
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_16_if.slave    bus
);
    div_state_t       state;
    div_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             accept;
    logic             last_step;
    logic             y_zero;

    logic [WIDTH-1:0] step_p;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;

    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             div_zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in    (rem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dvs),
        .p_out_c (step_p),
        .q_bit_c (step_q)
    );

    assign y_zero = (bus.y == '0);
    assign q_raw  = {dvd[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic x_neg;
    logic y_neg;
    logic neg_q;
    logic neg_r;
    logic ovf_pend;
    logic overflow;

    // Divide magnitudes, then restore signs: quotient by sign mismatch, remainder follows dividend
    always_comb begin
        x_neg = bus.Signed & bus.x[WIDTH-1];
        y_neg = bus.Signed & bus.y[WIDTH-1];
        x_mag = x_neg ? WIDTH'(-bus.x) : bus.x;
        y_mag = y_neg ? WIDTH'(-bus.y) : bus.y;
        q_fin = neg_q ? WIDTH'(-q_raw) : q_raw;
        r_fin = neg_r ? WIDTH'(-step_p) : step_p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            neg_q    <= x_neg ^ y_neg;
            neg_r    <= x_neg;
            ovf_pend <= bus.Signed && (bus.x == MOST_NEG) && (bus.y == '1);
            overflow <= 1'b0;
        end else if (last_step) begin
            overflow <= ovf_pend;
        end
    end

    assign bus.Overflow = overflow;
`else
    logic signed_unused;

    assign signed_unused = bus.Signed;
    assign x_mag         = bus.x;
    assign y_mag         = bus.y;
    assign q_fin         = q_raw;
    assign r_fin         = step_p;
    assign bus.Overflow  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; Start is only accepted outside CALC
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    accept   = 1'b1;
                    state_nx = y_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (bus.Start) begin
                    accept   = 1'b1;
                    state_nx = y_zero ? DONE : CALC;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_nx != CALC);
            busy  <= (state_nx == CALC);
            done  <= (state_nx == DONE);
        end
    end

    // Dividend register shifts out dividend bits and shifts in quotient bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= x_mag;
            dvs      <= y_mag;
            div_zero <= y_zero;
            if (y_zero) begin
                q_reg <= DIV0_Q;
                r_reg <= bus.x;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            rem <= step_p;
            dvd <= q_raw;
            if (last_step) begin
                q_reg <= q_fin;
                r_reg <= r_fin;
            end
        end
    end

    assign bus.Ready   = ready;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.q       = q_reg;
    assign bus.r       = r_reg;
    assign bus.DivZero = div_zero;
endmodule

// File: tb/tb_seq_divider_16.sv
// Directed bench for seq_divider_16: expected results queued at Start and
// compared at Done against an arithmetic model.
module tb_seq_divider_16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   edges  = 0;
    int   done_seen;
    exp_t scb[$];

    always #5 clk = ~clk;

    seq_divider_16_if bus ();

    seq_divider_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division, truncating toward zero when signed
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        exp_t e;
        logic s;
        int   sa;
        int   sd;
`ifdef DIV_SIGNED_EN
        s = sgn;
`else
        s = sgn & 1'b0;
`endif
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 16'h0000) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 8'd1;
        end else begin
            e.lat = 8'd17;
            if (s) begin
                sa = int'($signed(a));
                sd = int'($signed(b));
                if (a == 16'h8000 && b == 16'hFFFF) begin
                    e.q  = 16'h8000;
                    e.r  = 16'h0000;
                    e.ov = 1'b1;
                end else begin
                    e.q = 16'(sa / sd);
                    e.r = 16'(sa % sd);
                end
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        bus.x      = a;
        bus.y      = b;
        bus.Signed = sgn;
        bus.Start  = 1'b1;
        scb.push_back(model(a, b, sgn));
        @(negedge clk);
        bus.Start = 1'b0;
        edges     = 1;
    endtask

    task automatic poke_start(input logic [15:0] a, input logic [15:0] b);
        bus.x     = a;
        bus.y     = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        edges++;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        while (bus.Done !== 1'b1 && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        e = scb.pop_front();
        check({tag, ".done"},    32'(bus.Done),     32'd1);
        check({tag, ".latency"}, 32'(edges),        32'(e.lat));
        check({tag, ".q"},       32'(bus.q),        32'(e.q));
        check({tag, ".r"},       32'(bus.r),        32'(e.r));
        check({tag, ".divzero"}, 32'(bus.DivZero),  32'(e.dz));
        check({tag, ".overflow"},32'(bus.Overflow), 32'(e.ov));
        check({tag, ".ready"},   32'(bus.Ready),    32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        repeat (2) @(negedge clk);
        check("reset.ready",    32'(bus.Ready),    32'd1);
        check("reset.busy",     32'(bus.Busy),     32'd0);
        check("reset.done",     32'(bus.Done),     32'd0);
        check("reset.q",        32'(bus.q),        32'd0);
        check("reset.r",        32'(bus.r),        32'd0);
        check("reset.divzero",  32'(bus.DivZero),  32'd0);
        check("reset.overflow", 32'(bus.Overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_start(16'd100, 16'd7, 1'b0);
        wait_done("u100_7");
        @(negedge clk);
        check("u100_7.pulse_end", 32'(bus.Done), 32'd0);
        check("u100_7.q_hold",    32'(bus.q),    32'd14);
        check("u100_7.r_hold",    32'(bus.r),    32'd2);

        drive_start(16'h1234, 16'h0000, 1'b0);
        wait_done("div0");
        drive_start(16'd100, 16'd7, 1'b0);
        repeat (2) begin @(negedge clk); edges++; end
        check("flags_cleared.divzero", 32'(bus.DivZero), 32'd0);
        check("flags_cleared.busy",    32'(bus.Busy),    32'd1);
        wait_done("u100_7_again");
        @(negedge clk);

        drive_start(16'hFFFF, 16'd1, 1'b0);
        wait_done("ffff_1");
        @(negedge clk);
        drive_start(16'd5, 16'd9, 1'b0);
        wait_done("5_9");
        @(negedge clk);

        drive_start(16'd1000, 16'd3, 1'b0);
        repeat (3) begin @(negedge clk); edges++; end
        check("busy_ign.busy",  32'(bus.Busy),  32'd1);
        check("busy_ign.ready", 32'(bus.Ready), 32'd0);
        poke_start(16'd1, 16'd1);
        wait_done("busy_ign");
        drive_start(16'd50, 16'd5, 1'b0);
        wait_done("b2b");
        @(negedge clk);
        check("b2b.pulse_end", 32'(bus.Done), 32'd0);

        drive_start(16'hFFF9, 16'd2, 1'b0);
        wait_done("u_fff9_2");
        @(negedge clk);
        drive_start(16'hFFF9, 16'd2, 1'b1);
        wait_done("s_m7_2");
        @(negedge clk);
        drive_start(16'h8000, 16'hFFFF, 1'b1);
        wait_done("s_min_m1");
        @(negedge clk);
        drive_start(16'd7, 16'hFFFE, 1'b1);
        wait_done("s_7_m2");
        @(negedge clk);
        drive_start(16'hFFF9, 16'hFFFE, 1'b1);
        wait_done("s_m7_m2");
        @(negedge clk);
        drive_start(16'hFFF9, 16'h0000, 1'b1);
        wait_done("s_div0");
        @(negedge clk);

        // Abort a division partway through CALC
        drive_start(16'd100, 16'd7, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        scb.delete();
        check("midrst.ready",   32'(bus.Ready),   32'd1);
        check("midrst.busy",    32'(bus.Busy),    32'd0);
        check("midrst.done",    32'(bus.Done),    32'd0);
        check("midrst.q",       32'(bus.q),       32'd0);
        check("midrst.r",       32'(bus.r),       32'd0);
        check("midrst.divzero", 32'(bus.DivZero), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Done === 1'b1) done_seen++;
        end
        check("midrst.no_done", 32'(done_seen), 32'd0);
        drive_start(16'd1234, 16'd56, 1'b0);
        wait_done("after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
